axi_read_slave: RTL and testbench

AXI3 read-channel slave endpoint that sits downstream of the interconnect's slave-side AR/R ports (S*_AR*, S*_R*). It queues accepted read addresses and expands each into FIXED/INCR/WRAP beat addresses. It reads a single-port synchronous memory and returns data beats on R with RID, RRESP and RLAST. It is the slave-side counterpart of the master read path and terminates one slave port of the interconnect.

---
 rtl/axi_pkg.sv | 34 +++
 rtl/axi_read_slave_if.sv | 48 ++++
 rtl/axi_ar_fifo.sv | 59 +++++
 rtl/axi_read_slave.sv | 159 +++++++++++++++
 tb/tb_axi_read_slave.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 read-path types: burst/response encodings,
// AR field widths and the queued AR request record.
package axi_pkg;

  localparam int LEN_W     = 4;
  localparam int SIZE_W    = 3;
  localparam int BURST_W   = 2;
  localparam int RESP_W    = 2;
  localparam int AR_ID_W   = 2;
  localparam int AR_ADDR_W = 32;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef struct packed {
    logic [AR_ID_W-1:0]   id;
    logic [AR_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]     len;
    logic [SIZE_W-1:0]    size;
    burst_t               burst;
  } ar_req_t;

endpackage

// File: rtl/axi_read_slave_if.sv
// Slave-side AR/R bundle of one interconnect port.
// master drives AR and RREADY; slave drives ARREADY and R.
interface axi_read_slave_if
  import axi_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RID_WIDTH  = 2
);
  logic [RID_WIDTH-1:0]  Slave_in_ARID;
  logic [ADDR_WIDTH-1:0] Slave_in_ARADDR;
  logic [LEN_W-1:0]      Slave_in_ARLEN;
  logic [SIZE_W-1:0]     Slave_in_ARSIZE;
  logic [BURST_W-1:0]    Slave_in_ARBURST;
  logic [1:0]            Slave_in_ARLOCK;
  logic [3:0]            Slave_in_ARCACHE;
  logic [2:0]            Slave_in_ARPROT;
  logic                  Slave_in_ARVALID;
  logic                  Slave_out_ARREADY;
  logic [RID_WIDTH-1:0]  Slave_out_RID;
  logic [BUS_WIDTH-1:0]  Slave_out_RDATA;
  logic [3:0]            Slave_out_RRESP;
  logic                  Slave_out_RLAST;
  logic                  Slave_out_RVALID;
  logic                  Slave_in_RREADY;

  modport master (
    output Slave_in_ARID, Slave_in_ARADDR,
    output Slave_in_ARLEN, Slave_in_ARSIZE,
    output Slave_in_ARBURST, Slave_in_ARLOCK,
    output Slave_in_ARCACHE, Slave_in_ARPROT,
    output Slave_in_ARVALID, Slave_in_RREADY,
    input  Slave_out_ARREADY, Slave_out_RID,
    input  Slave_out_RDATA, Slave_out_RRESP,
    input  Slave_out_RLAST, Slave_out_RVALID
  );

  modport slave (
    input  Slave_in_ARID, Slave_in_ARADDR,
    input  Slave_in_ARLEN, Slave_in_ARSIZE,
    input  Slave_in_ARBURST, Slave_in_ARLOCK,
    input  Slave_in_ARCACHE, Slave_in_ARPROT,
    input  Slave_in_ARVALID, Slave_in_RREADY,
    output Slave_out_ARREADY, Slave_out_RID,
    output Slave_out_RDATA, Slave_out_RRESP,
    output Slave_out_RLAST, Slave_out_RVALID
  );
endinterface

// File: rtl/axi_ar_fifo.sv
// DEPTH-entry queue of accepted AR requests.
// Pushes beyond full and pops from empty are ignored.
module axi_ar_fifo
  import axi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  ar_req_t push_req,
  input  logic    pop,
  output ar_req_t pop_req,
  output logic    full,
  output logic    empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ar_req_t        slots [DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  cnt;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_req = slots[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wptr] <= push_req;
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI3 read slave: AR queue, burst expansion, 1-cycle memory.
// Define AXI_RD_SLVERR_EN to flag out-of-range/reserved beats.
module axi_read_slave
  import axi_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RID_WIDTH  = 2,
  parameter int DEPTH      = 2,
  parameter int MEM_AW     = 10
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axi_read_slave_if.slave   bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [BUS_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {
    S_IDLE, S_RD, S_CAP, S_RSP
  } state_t;

  state_t  state, state_nx;
  ar_req_t push_req, pop_req;
  logic    full, empty, pop, rd_en, err;

  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [ADDR_WIDTH-1:0] step, wmask, inc;
  logic [LEN_W-1:0]      beat_cnt, len;
  logic [1:0]            sz;
  burst_t                burst;
  logic [RID_WIDTH-1:0]  rid;
  logic [BUS_WIDTH-1:0]  rdata;
  resp_t                 rresp;
  logic                  rvalid, rlast;

  assign push_req = '{
    id:    bus.Slave_in_ARID,
    addr:  bus.Slave_in_ARADDR,
    len:   bus.Slave_in_ARLEN,
    size:  bus.Slave_in_ARSIZE,
    burst: burst_t'(bus.Slave_in_ARBURST)
  };

  axi_ar_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .push     (bus.Slave_in_ARVALID),
    .push_req (push_req),
    .pop      (pop),
    .pop_req  (pop_req),
    .full     (full),
    .empty    (empty)
  );

  assign bus.Slave_out_ARREADY = !full;
  assign bus.Slave_out_RID     = rid;
  assign bus.Slave_out_RDATA   = rdata;
  assign bus.Slave_out_RRESP   = {2'b00, rresp};
  assign bus.Slave_out_RLAST   = rlast;
  assign bus.Slave_out_RVALID  = rvalid;

  logic unused_ok;
  assign unused_ok = ^{bus.Slave_in_ARLOCK,
                       bus.Slave_in_ARCACHE,
                       bus.Slave_in_ARPROT};

`ifdef AXI_RD_SLVERR_EN
  assign err = (|addr[ADDR_WIDTH-1:MEM_AW+2])
            || (burst == BURST_RSVD);
`else
  assign err = 1'b0;
`endif

  assign mem_rd   = rd_en && !err;
  assign mem_addr = rd_en ? addr[MEM_AW+1:2] : '0;

  // wmask = wrap boundary - 1 = (len+1)*step - 1
  always_comb begin
    step    = ADDR_WIDTH'(1) << sz;
    wmask   = ((ADDR_WIDTH'(len) + 1'b1) << sz) - 1'b1;
    inc     = addr + step;
    addr_nx = inc;
    case (burst)
      BURST_FIXED: addr_nx = addr;
      BURST_WRAP:  addr_nx = (addr & ~wmask)
                           | (inc & wmask);
      default:     addr_nx = inc;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    rd_en    = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        pop      = 1'b1;
        state_nx = S_RD;
      end
      S_RD: begin
        rd_en    = 1'b1;
        state_nx = S_CAP;
      end
      S_CAP: state_nx = S_RSP;
      S_RSP: if (bus.Slave_in_RREADY) begin
        state_nx = rlast ? S_IDLE : S_RD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr     <= '0;
      beat_cnt <= '0;
      len      <= '0;
      sz       <= '0;
      burst    <= BURST_FIXED;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          addr     <= pop_req.addr;
          beat_cnt <= '0;
          len      <= pop_req.len;
          sz       <= (pop_req.size > 3'd2) ? 2'd2
                    : pop_req.size[1:0];
          burst    <= pop_req.burst;
          rid      <= pop_req.id;
        end
        S_CAP: begin
          rdata  <= err ? '0 : mem_rdata;
          rresp  <= err ? RESP_SLVERR : RESP_OKAY;
          rvalid <= 1'b1;
          rlast  <= (beat_cnt == len);
        end
        S_RSP: if (bus.Slave_in_RREADY) begin
          rvalid <= 1'b0;
          if (!rlast) begin
            beat_cnt <= beat_cnt + 1'b1;
            addr     <= addr_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: burst table plus
// back-pressure and mid-burst reset sequences.
module tb_axi_read_slave;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_read_slave_if #(
    .BUS_WIDTH(32), .ADDR_WIDTH(32), .RID_WIDTH(2)
  ) bus ();

  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;

  axi_read_slave #(
    .BUS_WIDTH(32), .ADDR_WIDTH(32), .RID_WIDTH(2),
    .DEPTH(2), .MEM_AW(10)
  ) dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem [1024];

  function automatic logic [31:0] mval(input logic [9:0] wa);
    return (wa == 10'd4) ? 32'hDEADBEEF : {16'hC0DE, 6'd0, wa};
  endfunction

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]       id;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0][9:0]  wa;
    logic [3:0]       err;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(
    input logic [1:0] id, input logic [31:0] a,
    input logic [3:0] len, input logic [2:0] sz,
    input logic [1:0] bu, input logic [9:0] w0,
    input logic [9:0] w1, input logic [9:0] w2,
    input logic [9:0] w3);
    vec_t v;
    v.id = id; v.addr = a; v.len = len; v.size = sz;
    v.burst = bu; v.err = 4'b0;
    v.wa = {w3, w2, w1, w0};
    return v;
  endfunction

  task automatic set_ar(input vec_t v);
    bus.Slave_in_ARID    = v.id;
    bus.Slave_in_ARADDR  = v.addr;
    bus.Slave_in_ARLEN   = v.len;
    bus.Slave_in_ARSIZE  = v.size;
    bus.Slave_in_ARBURST = v.burst;
  endtask

  // returns at the negedge right after the AR handshake edge
  task automatic send_ar(input vec_t v, input string nm);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    set_ar(v);
    bus.Slave_in_ARVALID = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.Slave_out_ARREADY) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk({nm, " arready timeout"}, 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.Slave_in_ARVALID = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cyc, last_rv, rd_cnt;
    logic [9:0] rd_a;
    logic got, e;
    bus.Slave_in_RREADY = 1'b1;
    send_ar(v, nm);
    cyc = 0;
    last_rv = 0;
    for (int b = 0; b <= int'(v.len); b++) begin
      rd_cnt = 0;
      rd_a = '0;
      got = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (mem_rd) begin
          rd_cnt++;
          rd_a = mem_addr;
        end
        if (bus.Slave_out_RVALID) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("%s b%0d rvalid", nm, b), got, 1);
      if (!got) return;
      e = v.err[b];
      chk($sformatf("%s b%0d gap", nm, b), cyc - last_rv, 3);
      last_rv = cyc;
      chk($sformatf("%s b%0d mem_rd", nm, b), rd_cnt, e ? 0 : 1);
      if (!e)
        chk($sformatf("%s b%0d mem_addr", nm, b), rd_a, v.wa[b]);
      chk($sformatf("%s b%0d rdata", nm, b),
          bus.Slave_out_RDATA, e ? 32'd0 : mval(v.wa[b]));
      chk($sformatf("%s b%0d rid", nm, b), bus.Slave_out_RID, v.id);
      chk($sformatf("%s b%0d rlast", nm, b),
          bus.Slave_out_RLAST, b == int'(v.len));
      chk($sformatf("%s b%0d rresp", nm, b),
          bus.Slave_out_RRESP, e ? 4'd2 : 4'd0);
      @(negedge clk);
      cyc++;
    end
    chk({nm, " rvalid drop"}, bus.Slave_out_RVALID, 0);
  endtask

  vec_t bp [4];
  vec_t ra, rb;
  int   nb, nrv;
  logic hs_ar, ar4_acc, stray;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = mval(10'(i));
    mem_rdata = '0;
    bus.Slave_in_ARVALID = 1'b0;
    bus.Slave_in_RREADY  = 1'b0;
    bus.Slave_in_ARLOCK  = '0;
    bus.Slave_in_ARCACHE = '0;
    bus.Slave_in_ARPROT  = '0;

    tbl[0] = mk(2'd2, 32'h10, 4'd0, 3'd2, 2'b01, 10'h004, 0, 0, 0);
    tbl[1] = mk(2'd1, 32'h100, 4'd3, 3'd2, 2'b01,
                10'h040, 10'h041, 10'h042, 10'h043);
    tbl[2] = mk(2'd3, 32'h38, 4'd3, 3'd2, 2'b10,
                10'h00E, 10'h00F, 10'h00C, 10'h00D);
    tbl[3] = mk(2'd0, 32'h20, 4'd2, 3'd2, 2'b00,
                10'h008, 10'h008, 10'h008, 0);
    tbl[4] = mk(2'd1, 32'h1000, 4'd0, 3'd2, 2'b01, 10'h000, 0, 0, 0);
    tbl[5] = mk(2'd2, 32'h200, 4'd1, 3'd5, 2'b01,
                10'h080, 10'h081, 0, 0);
    tbl[6] = mk(2'd3, 32'h41, 4'd3, 3'd0, 2'b01,
                10'h010, 10'h010, 10'h010, 10'h011);
    tbl[7] = mk(2'd0, 32'h300, 4'd1, 3'd2, 2'b11,
                10'h0C0, 10'h0C1, 0, 0);
    tbl[8] = mk(2'd1, 32'h44, 4'd1, 3'd2, 2'b10,
                10'h011, 10'h010, 0, 0);
    tbl[9] = mk(2'd2, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01,
                10'h3FF, 10'h000, 0, 0);
`ifdef AXI_RD_SLVERR_EN
    tbl[4].err = 4'b0001;
    tbl[7].err = 4'b0011;
    tbl[9].err = 4'b0001;
`endif

    repeat (3) @(negedge clk);
    chk("rst arready", bus.Slave_out_ARREADY, 1);
    chk("rst rvalid", bus.Slave_out_RVALID, 0);
    chk("rst rlast", bus.Slave_out_RLAST, 0);
    chk("rst rid", bus.Slave_out_RID, 0);
    chk("rst rdata", bus.Slave_out_RDATA, 0);
    chk("rst rresp", bus.Slave_out_RRESP, 0);
    chk("rst mem_rd", mem_rd, 0);
    chk("rst mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // back-pressure: queue of two plus one in flight
    for (int i = 0; i < 4; i++)
      bp[i] = mk(2'(i), 32'h400 + 32'(4 * i), 4'd0, 3'd2, 2'b01,
                 10'h100 + 10'(i), 0, 0, 0);
    bus.Slave_in_RREADY = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      set_ar(bp[i]);
      bus.Slave_in_ARVALID = 1'b1;
      chk($sformatf("bp arready %0d", i), bus.Slave_out_ARREADY, 1);
      @(posedge clk);
      @(negedge clk);
    end
    set_ar(bp[3]);
    chk("bp full", bus.Slave_out_ARREADY, 0);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp stall rvalid %0d", k), bus.Slave_out_RVALID, 1);
      chk($sformatf("bp stall rdata %0d", k),
          bus.Slave_out_RDATA, mval(10'h100));
      chk($sformatf("bp stall rid %0d", k), bus.Slave_out_RID, 0);
      chk($sformatf("bp stall arready %0d", k),
          bus.Slave_out_ARREADY, 0);
      @(negedge clk);
    end
    bus.Slave_in_RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nb = 0;
    ar4_acc = 1'b0;
    for (int k = 0; k < 40 && nb < 3; k++) begin
      hs_ar = bus.Slave_in_ARVALID && bus.Slave_out_ARREADY;
      if (bus.Slave_out_RVALID) begin
        chk($sformatf("bp rid %0d", nb),
            bus.Slave_out_RID, bp[nb+1].id);
        chk($sformatf("bp rdata %0d", nb),
            bus.Slave_out_RDATA, mval(bp[nb+1].wa[0]));
        chk($sformatf("bp rlast %0d", nb), bus.Slave_out_RLAST, 1);
        nb++;
      end
      @(negedge clk);
      if (hs_ar) begin
        bus.Slave_in_ARVALID = 1'b0;
        ar4_acc = 1'b1;
      end
    end
    chk("bp 4th accepted", ar4_acc, 1);
    chk("bp drained", nb, 3);

    // reset during beat 2 of a 4-beat burst, one more queued
    ra = mk(2'd1, 32'h500, 4'd3, 3'd2, 2'b01,
            10'h140, 10'h141, 10'h142, 10'h143);
    rb = mk(2'd2, 32'h600, 4'd0, 3'd2, 2'b01, 10'h180, 0, 0, 0);
    bus.Slave_in_RREADY = 1'b1;
    send_ar(ra, "rst A");
    send_ar(rb, "rst B");
    nrv = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.Slave_out_RVALID) begin
        nrv++;
        if (nrv == 2) break;
      end
      @(negedge clk);
    end
    chk("rst beat2 seen", nrv, 2);
    chk("rst beat2 rdata", bus.Slave_out_RDATA, mval(10'h141));
    #1 rst_n = 1'b0;
    #1;
    chk("rst mid rvalid", bus.Slave_out_RVALID, 0);
    chk("rst mid arready", bus.Slave_out_ARREADY, 1);
    chk("rst mid mem_rd", mem_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.Slave_out_RVALID || mem_rd) stray = 1'b1;
    end
    chk("rst no beats after", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
